dms_pfd: RTL and testbench

Clocked tri-state phase-frequency detector for the DMS CDR loop. It sits directly upstream of the charge pump and drives its `up`/`down` control inputs. The block samples the asynchronous reference and feedback clocks on a fast oversampling clock and generates UP/DOWN pulses with a programmable anti-deadzone overlap. It also measures each pulse width as a signed phase error, flags runaway pulses and reports loop lock.

---
 rtl/dms_pfd.sv | 191 +++++++++++++++++++
 tb/tb_dms_pfd.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/dms_pfd.sv
// rtl/dms_pfd.sv - clocked tri-state phase-frequency detector with anti-deadzone overlap,
// signed pulse-width error, saturation flag and lock detection.
module dms_pfd #(
   parameter int DEADZONE_CYC  = 2,
   parameter int MAX_PULSE_CYC = 255,
   parameter int CNT_W         = 8,
   parameter int LOCK_N        = 4,
   parameter int LOCK_TOL      = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic             ref_in,
   input  logic             fb_in,
   output logic             up,
   output logic             down,
   output logic [CNT_W:0]   err_o,
   output logic             err_valid,
   output logic             sat_o,
   output logic             lock_o
);

   localparam int LCK_W = (LOCK_N < 2) ? 1 : $clog2(LOCK_N + 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_UP   = 2'd1,
      ST_DOWN = 2'd2,
      ST_BOTH = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [2:0]        ref_sync_q, ref_sync_d;
   logic [2:0]        fb_sync_q, fb_sync_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CNT_W:0]    err_q, err_d;
   logic              err_valid_q, err_valid_d;
   logic              sat_q, sat_d;
   logic [LCK_W-1:0]  lock_cnt_q, lock_cnt_d;
   logic              lock_q, lock_d;
   logic              up_q, up_d;
   logic              down_q, down_d;

   logic              ref_rise, fb_rise;
   logic [CNT_W:0]    cnt_pos, cnt_neg, max_pos, max_neg, err_abs;

   assign ref_rise = ref_sync_q[1] & ~ref_sync_q[2];
   assign fb_rise  = fb_sync_q[1] & ~fb_sync_q[2];

   assign cnt_pos = {1'b0, cnt_q};
   assign cnt_neg = ~cnt_pos + {{CNT_W{1'b0}}, 1'b1};
   assign max_pos = {1'b0, CNT_W'(MAX_PULSE_CYC)};
   assign max_neg = ~max_pos + {{CNT_W{1'b0}}, 1'b1};
   assign err_abs = err_q[CNT_W] ? (~err_q + {{CNT_W{1'b0}}, 1'b1}) : err_q;

   always_comb begin
      // Synchronizers free-run regardless of enable so no stale edge appears on re-enable
      ref_sync_d  = {ref_sync_q[1:0], ref_in};
      fb_sync_d   = {fb_sync_q[1:0], fb_in};
      state_d     = state_q;
      cnt_d       = cnt_q;
      err_d       = err_q;
      err_valid_d = 1'b0;
      sat_d       = 1'b0;
      lock_cnt_d  = lock_cnt_q;

      case (state_q)
         ST_IDLE: begin
            if (ref_rise && fb_rise) begin
               state_d     = ST_BOTH;
               cnt_d       = CNT_W'(1);
               err_d       = '0;
               err_valid_d = 1'b1;
            end else if (ref_rise) begin
               state_d = ST_UP;
               cnt_d   = CNT_W'(1);
            end else if (fb_rise) begin
               state_d = ST_DOWN;
               cnt_d   = CNT_W'(1);
            end
         end
         ST_UP: begin
            if (fb_rise) begin
               state_d     = ST_BOTH;
               cnt_d       = CNT_W'(1);
               err_d       = cnt_pos;
               err_valid_d = 1'b1;
            end else if (cnt_q == CNT_W'(MAX_PULSE_CYC)) begin
               state_d     = ST_IDLE;
               cnt_d       = '0;
               err_d       = max_pos;
               err_valid_d = 1'b1;
               sat_d       = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_DOWN: begin
            if (ref_rise) begin
               state_d     = ST_BOTH;
               cnt_d       = CNT_W'(1);
               err_d       = cnt_neg;
               err_valid_d = 1'b1;
            end else if (cnt_q == CNT_W'(MAX_PULSE_CYC)) begin
               state_d     = ST_IDLE;
               cnt_d       = '0;
               err_d       = max_neg;
               err_valid_d = 1'b1;
               sat_d       = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_BOTH: begin
            // cnt counts overlap cycles here; the pulse width was already captured in err
            if (cnt_q >= CNT_W'(DEADZONE_CYC)) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase

      if (err_valid_q) begin
         if (err_abs <= (CNT_W+1)'(LOCK_TOL)) begin
            if (lock_cnt_q < LCK_W'(LOCK_N)) begin
               lock_cnt_d = lock_cnt_q + LCK_W'(1);
            end
         end else begin
            lock_cnt_d = '0;
         end
      end
      if (sat_q) begin
         lock_cnt_d = '0;
      end

      if (!enable) begin
         state_d     = ST_IDLE;
         cnt_d       = '0;
         err_d       = err_q;
         err_valid_d = 1'b0;
         sat_d       = 1'b0;
         lock_cnt_d  = '0;
      end

      lock_d = (lock_cnt_d == LCK_W'(LOCK_N));
      up_d   = enable && (state_q == ST_UP || state_q == ST_BOTH);
      down_d = enable && (state_q == ST_DOWN || state_q == ST_BOTH);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         ref_sync_q  <= '0;
         fb_sync_q   <= '0;
         cnt_q       <= '0;
         err_q       <= '0;
         err_valid_q <= 1'b0;
         sat_q       <= 1'b0;
         lock_cnt_q  <= '0;
         lock_q      <= 1'b0;
         up_q        <= 1'b0;
         down_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         ref_sync_q  <= ref_sync_d;
         fb_sync_q   <= fb_sync_d;
         cnt_q       <= cnt_d;
         err_q       <= err_d;
         err_valid_q <= err_valid_d;
         sat_q       <= sat_d;
         lock_cnt_q  <= lock_cnt_d;
         lock_q      <= lock_d;
         up_q        <= up_d;
         down_q      <= down_d;
      end
   end

   assign up        = up_q;
   assign down      = down_q;
   assign err_o     = err_q;
   assign err_valid = err_valid_q;
   assign sat_o     = sat_q;
   assign lock_o    = lock_q;

endmodule

// File: tb/tb_dms_pfd.sv
// tb/tb_dms_pfd.sv - scoreboard bench for dms_pfd: expected errors and pulse widths are
// queued by the stimulus and popped by a negedge monitor.
module tb_dms_pfd;

   localparam int DZ    = 2;
   localparam int MAXP  = 255;
   localparam int CNT_W = 8;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             enable = 1'b1;
   logic             ref_in = 1'b0;
   logic             fb_in = 1'b0;
   logic             up, down, err_valid, sat_o, lock_o;
   logic [CNT_W:0]   err_o;

   int checks = 0;
   int passed = 0;

   int err_exp_q[$];
   bit sat_exp_q[$];
   int width_exp_q[$];
   int ovl_exp_q[$];

   int up_run = 0;
   int dn_run = 0;
   int ov_run = 0;

   dms_pfd #(
      .DEADZONE_CYC (DZ),
      .MAX_PULSE_CYC(MAXP),
      .CNT_W        (CNT_W),
      .LOCK_N       (4),
      .LOCK_TOL     (1)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .enable   (enable),
      .ref_in   (ref_in),
      .fb_in    (fb_in),
      .up       (up),
      .down     (down),
      .err_o    (err_o),
      .err_valid(err_valid),
      .sat_o    (sat_o),
      .lock_o   (lock_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act == exp) passed++;
      else $display("FAIL %s actual=%0d required=%0d", name, act, exp);
   endtask

   // Monitor: consumes expectations whenever the DUT presents an event
   always @(negedge clk) begin
      if (!rst_n) begin
         up_run = 0;
         dn_run = 0;
         ov_run = 0;
      end else begin
         if (err_valid) begin
            if (err_exp_q.size() == 0) begin
               chk("unexpected_err_valid", 1, 0);
            end else begin
               logic [CNT_W:0] e;
               e = CNT_W'(0);
               e = err_exp_q.pop_front();
               chk("err_o", err_o, e);
               chk("sat_o", sat_o, sat_exp_q.pop_front());
            end
         end else if (sat_o) begin
            chk("sat_without_valid", 1, 0);
         end

         if (up && !down) up_run++;
         else if (up_run > 0) begin
            if (width_exp_q.size() == 0) chk("unexpected_up_pulse", up_run, 0);
            else chk("up_width", up_run, width_exp_q.pop_front());
            up_run = 0;
         end

         if (down && !up) dn_run++;
         else if (dn_run > 0) begin
            if (width_exp_q.size() == 0) chk("unexpected_down_pulse", dn_run, 0);
            else chk("down_width", -dn_run, width_exp_q.pop_front());
            dn_run = 0;
         end

         if (up && down) ov_run++;
         else if (ov_run > 0) begin
            if (ovl_exp_q.size() == 0) chk("unexpected_overlap", ov_run, 0);
            else chk("overlap_width", ov_run, ovl_exp_q.pop_front());
            ov_run = 0;
         end
      end
   end

   // lead > 0: ref rises lead cycles before fb; lead < 0: fb leads; 0: coincident
   task automatic pair(input int lead);
      int mag;
      mag = (lead < 0) ? -lead : lead;
      @(negedge clk);
      if (lead >= 0) ref_in = 1'b1;
      if (lead <= 0) fb_in = 1'b1;
      err_exp_q.push_back(lead);
      sat_exp_q.push_back(1'b0);
      if (lead != 0) width_exp_q.push_back(lead);
      ovl_exp_q.push_back(DZ);
      for (int j = 1; j <= mag; j++) begin
         @(negedge clk);
         if (mag >= 5 && j == 3) chk("latency_pre", (lead > 0) ? up : down, 0);
         if (mag >= 5 && j == 4) chk("latency_k3", (lead > 0) ? up : down, 1);
      end
      if (lead > 0) fb_in = 1'b1;
      else if (lead < 0) ref_in = 1'b1;
      repeat (10) @(negedge clk);
      ref_in = 1'b0;
      fb_in  = 1'b0;
      repeat (12) @(negedge clk);
   endtask

   task automatic lock4();
      pair(1);
      pair(-1);
      pair(1);
      chk("lock_after_3", lock_o, 0);
      pair(-1);
      chk("lock_after_4", lock_o, 1);
   endtask

   initial begin
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         ref_in = i[0];
         fb_in  = ~i[0];
      end
      chk("rst_up", up, 0);
      chk("rst_down", down, 0);
      chk("rst_err_valid", err_valid, 0);
      chk("rst_sat", sat_o, 0);
      chk("rst_lock", lock_o, 0);
      chk("rst_err_o", err_o, 0);
      ref_in = 1'b0;
      fb_in  = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      pair(0);
      pair(10);
      pair(-4);
      lock4();
      pair(5);
      chk("lock_drop_err5", lock_o, 0);
      lock4();

      // Missing fb: saturate at MAXP
      @(negedge clk);
      ref_in = 1'b1;
      err_exp_q.push_back(MAXP);
      sat_exp_q.push_back(1'b1);
      width_exp_q.push_back(MAXP);
      repeat (270) @(negedge clk);
      chk("lock_drop_sat", lock_o, 0);
      ref_in = 1'b0;
      repeat (12) @(negedge clk);

      pair(255);
      lock4();

      // Abort mid-UP by dropping enable
      @(negedge clk);
      ref_in = 1'b1;
      width_exp_q.push_back(4);
      repeat (7) @(negedge clk);
      chk("up_before_disable", up, 1);
      enable = 1'b0;
      @(posedge clk);
      #1;
      chk("up_after_disable", up, 0);
      chk("lock_after_disable", lock_o, 0);
      repeat (10) @(negedge clk);
      enable = 1'b1;
      repeat (10) @(negedge clk);
      ref_in = 1'b0;
      repeat (12) @(negedge clk);
      pair(3);

      chk("err_queue_empty", err_exp_q.size(), 0);
      chk("width_queue_empty", width_exp_q.size(), 0);
      chk("ovl_queue_empty", ovl_exp_q.size(), 0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
